// File: rtl/context_alloc_manage_pkg.sv
// Shared constants and one-hot/binary id helpers for the context allocation manager.
package context_alloc_manage_pkg;

   localparam int unsigned MAX_CNTX     = 32;
   localparam int unsigned MAX_CID_W    = 5;
   localparam int unsigned CNTX_INIT_ID = 0;
   localparam logic [31:0] WORD_ZERO    = '0;

   function automatic logic [MAX_CID_W-1:0] onehot2bin(input logic [MAX_CNTX-1:0] oh);
      logic [MAX_CID_W-1:0] b;
      b = '0;
      for (int i = 0; i < MAX_CNTX; i++) begin
         if (oh[i]) b = b | MAX_CID_W'(i);
      end
      return b;
   endfunction

   function automatic logic [MAX_CNTX-1:0] bin2onehot(input logic [MAX_CID_W-1:0] b);
      return MAX_CNTX'(1) << b;
   endfunction

endpackage

// File: rtl/context_alloc_manage_free_pick.sv
// cntx_free_pick: lowest two free context ids plus a popcount of free contexts.
module cntx_free_pick #(
   parameter int unsigned N_CNTX = 8,
   parameter int unsigned CID_W  = $clog2(N_CNTX)
) (
   input  logic [N_CNTX-1:0] busy,
   output logic [CID_W-1:0]  first_cid,
   output logic [CID_W-1:0]  second_cid,
   output logic [CID_W:0]    free_cnt
);

   logic found_first;
   logic found_second;

   always_comb begin
      first_cid    = '0;
      second_cid   = '0;
      free_cnt     = '0;
      found_first  = 1'b0;
      found_second = 1'b0;
      for (int i = 0; i < N_CNTX; i++) begin
         if (!busy[i]) begin
            free_cnt = free_cnt + (CID_W+1)'(1);
            if (!found_first) begin
               first_cid   = CID_W'(i);
               found_first = 1'b1;
            end else if (!found_second) begin
               second_cid   = CID_W'(i);
               found_second = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/context_alloc_manage.sv
// Speculative fetch-context manager with free-list allocation and decode back-pressure.
// Optional stall performance counter: define CNTX_STALL_CNT_EN.
module context_alloc_manage
   import context_alloc_manage_pkg::*;
#(
   parameter int unsigned       N_CNTX   = 8,
   parameter int unsigned       CID_W    = $clog2(N_CNTX),
   parameter int unsigned       WORD_W   = 32,
   parameter logic [WORD_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              init,
   input  logic              fetch_ready,
   output logic              fetch_req,
   input  logic              fetch_ack,
   output logic [WORD_W-1:0] fetch_pc,
   output logic [CID_W-1:0]  fetch_cid,
   input  logic              dec_valid,
   input  logic [CID_W-1:0]  dec_cid,
   input  logic              dec_next_ready,
   input  logic [WORD_W-1:0] dec_next_pc,
   input  logic              dec_branch,
   input  logic [WORD_W-1:0] dec_pc_f,
   output logic              dec_stall,
   output logic [CID_W-1:0]  alloc_t_cid,
   output logic [CID_W-1:0]  alloc_f_cid,
   input  logic              jb_valid,
   input  logic [CID_W-1:0]  jb_cid,
   input  logic [WORD_W-1:0] jb_pc,
   input  logic              br_valid,
   input  logic              br_hazard,
   input  logic [CID_W-1:0]  br_bad_cid,
   input  logic [CID_W-1:0]  br_good_cid,
   output logic [N_CNTX-1:0] squash_mask,
   // "release" is a reserved word, hence the suffix
   input  logic [N_CNTX-1:0] release_mask,
   output logic [CID_W:0]    free_cnt,
   output logic [31:0]       stall_cnt
);

   function automatic logic [N_CNTX-1:0] to_oh(input logic [CID_W-1:0] id);
      return N_CNTX'(bin2onehot(MAX_CID_W'(id)));
   endfunction

   localparam logic [N_CNTX-1:0] INIT_OH = N_CNTX'(bin2onehot(MAX_CID_W'(CNTX_INIT_ID)));
   localparam logic [N_CNTX-1:0][N_CNTX-1:0] INIT_KILL =
      (N_CNTX*N_CNTX)'(INIT_OH) << (CNTX_INIT_ID*N_CNTX);
   localparam logic [N_CNTX-1:0][WORD_W-1:0] INIT_PC =
      (N_CNTX*WORD_W)'(RESET_PC) << (CNTX_INIT_ID*WORD_W);

   logic [N_CNTX-1:0]             busy_q, busy_d;
   logic [N_CNTX-1:0]             pending_q, pending_d;
   logic [N_CNTX-1:0]             hot_q, hot_d;
   logic [N_CNTX-1:0][N_CNTX-1:0] kill_q, kill_d;
   logic [N_CNTX-1:0][WORD_W-1:0] pc_q, pc_d;
   logic [CID_W-1:0]              hot_cid;
   logic                          dec_ok;
   logic                          alloc_en;
   logic [N_CNTX-1:0]             alloc_oh;
   logic [N_CNTX-1:0]             rel;

   cntx_free_pick #(.N_CNTX(N_CNTX), .CID_W(CID_W)) u_free_pick (
      .busy       (busy_q),
      .first_cid  (alloc_t_cid),
      .second_cid (alloc_f_cid),
      .free_cnt   (free_cnt)
   );

   assign dec_stall = free_cnt < (CID_W+1)'(2);

   // Stage 1 (squash, jump) then stage 2 (fetch, decode, allocate, release) on the stage-1 view.
   always_comb begin
      squash_mask = '0;
      fetch_pc    = WORD_W'(WORD_ZERO);
      fetch_req   = 1'b0;
      hot_cid     = '0;
      dec_ok      = 1'b0;
      alloc_en    = 1'b0;
      alloc_oh    = '0;
      rel         = '0;
      busy_d      = busy_q;
      pending_d   = pending_q;
      hot_d       = hot_q;
      kill_d      = kill_q;
      pc_d        = pc_q;

      if (br_valid && br_hazard) squash_mask = kill_q[br_bad_cid];
      busy_d    = busy_q & ~squash_mask;
      pending_d = pending_q & ~squash_mask;
      for (int i = 0; i < N_CNTX; i++) begin
         kill_d[i] = squash_mask[i] ? '0 : (kill_q[i] & ~squash_mask);
      end
      if ((hot_q & squash_mask) != '0) hot_d = to_oh(br_good_cid);
      if (jb_valid && !squash_mask[jb_cid]) begin
         pc_d[jb_cid]      = jb_pc;
         pending_d[jb_cid] = 1'b1;
      end

      hot_cid   = CID_W'(onehot2bin(MAX_CNTX'(hot_d)));
      fetch_req = pending_d[hot_cid] & fetch_ready;
      fetch_pc  = pc_d[hot_cid];
      if (fetch_ack) pending_d[hot_cid] = 1'b0;

      // busy_d here already excludes squashed contexts, so killed/free decodes drop out
      dec_ok = dec_valid && busy_d[dec_cid];
      if (dec_ok && dec_next_ready) begin
         pc_d[dec_cid]      = dec_next_pc;
         pending_d[dec_cid] = 1'b1;
      end

      alloc_en = dec_ok && dec_branch && !dec_stall;
      if (alloc_en) begin
         alloc_oh = to_oh(alloc_t_cid) | to_oh(alloc_f_cid);
         for (int i = 0; i < N_CNTX; i++) begin
            if (kill_d[i][dec_cid]) kill_d[i] = kill_d[i] | alloc_oh;
         end
         kill_d[alloc_t_cid] = to_oh(alloc_t_cid);
         kill_d[alloc_f_cid] = to_oh(alloc_f_cid);
         pc_d[alloc_t_cid]   = dec_next_pc;
         pc_d[alloc_f_cid]   = dec_pc_f;
         busy_d              = busy_d | alloc_oh;
         pending_d           = pending_d | alloc_oh;
         hot_d               = to_oh(alloc_t_cid);
      end

      rel       = release_mask & busy_d & ~hot_d & ~alloc_oh;
      busy_d    = busy_d & ~rel;
      pending_d = pending_d & ~rel;
      for (int i = 0; i < N_CNTX; i++) begin
         kill_d[i] = rel[i] ? '0 : (kill_d[i] & ~rel);
      end
   end

   assign fetch_cid = hot_cid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_q    <= INIT_OH;
         pending_q <= INIT_OH;
         hot_q     <= INIT_OH;
         kill_q    <= INIT_KILL;
         pc_q      <= INIT_PC;
      end else if (init) begin
         busy_q    <= INIT_OH;
         pending_q <= INIT_OH;
         hot_q     <= INIT_OH;
         kill_q    <= INIT_KILL;
         pc_q      <= INIT_PC;
      end else begin
         busy_q    <= busy_d;
         pending_q <= pending_d;
         hot_q     <= hot_d;
         kill_q    <= kill_d;
         pc_q      <= pc_d;
      end
   end

`ifdef CNTX_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt_q <= '0;
      end else if (init) begin
         stall_cnt_q <= '0;
      end else if (dec_stall && dec_valid && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

   // Decode must not present a branch while back-pressured
   a_no_branch_in_stall : assert property (@(posedge clk) disable iff (!rstn)
      !(dec_valid && dec_branch && dec_stall));

endmodule

// File: tb/tb_context_alloc_manage.sv
// Directed self-checking bench for context_alloc_manage (8-context and 4-context instances).
module tb_context_alloc_manage;

   logic        clk = 1'b0;
   logic        rstn, init, fetch_ready, fetch_ack;
   logic        dec_valid, dec_next_ready, dec_branch, phase2;
   logic [2:0]  dec_cid, jb_cid, br_bad_cid, br_good_cid;
   logic [31:0] dec_next_pc, dec_pc_f, jb_pc;
   logic        jb_valid, br_valid, br_hazard;
   logic [7:0]  release_mask;

   logic        fetch_req8, dec_stall8;
   logic [31:0] fetch_pc8, stall_cnt8;
   logic [2:0]  fetch_cid8, alloc_t8, alloc_f8;
   logic [7:0]  squash8;
   logic [3:0]  free8;

   logic        fetch_req4, dec_stall4, dec_branch4;
   logic [31:0] fetch_pc4, stall_cnt4;
   logic [1:0]  fetch_cid4, alloc_t4, alloc_f4;
   logic [1:0]  dec_cid4, jb_cid4, bad4, good4;
   logic [3:0]  squash4, release4;
   logic [2:0]  free4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign dec_cid4    = dec_cid[1:0];
   assign jb_cid4     = jb_cid[1:0];
   assign bad4        = br_bad_cid[1:0];
   assign good4       = br_good_cid[1:0];
   assign release4    = release_mask[3:0];
   assign dec_branch4 = dec_branch & phase2;

   context_alloc_manage #(.N_CNTX(8), .WORD_W(32), .RESET_PC(32'h100)) u8 (
      .clk(clk), .rstn(rstn), .init(init), .fetch_ready(fetch_ready),
      .fetch_req(fetch_req8), .fetch_ack(fetch_ack), .fetch_pc(fetch_pc8), .fetch_cid(fetch_cid8),
      .dec_valid(dec_valid), .dec_cid(dec_cid), .dec_next_ready(dec_next_ready),
      .dec_next_pc(dec_next_pc), .dec_branch(dec_branch), .dec_pc_f(dec_pc_f),
      .dec_stall(dec_stall8), .alloc_t_cid(alloc_t8), .alloc_f_cid(alloc_f8),
      .jb_valid(jb_valid), .jb_cid(jb_cid), .jb_pc(jb_pc),
      .br_valid(br_valid), .br_hazard(br_hazard), .br_bad_cid(br_bad_cid), .br_good_cid(br_good_cid),
      .squash_mask(squash8), .release_mask(release_mask), .free_cnt(free8), .stall_cnt(stall_cnt8)
   );

   context_alloc_manage #(.N_CNTX(4), .WORD_W(32), .RESET_PC(32'h100)) u4 (
      .clk(clk), .rstn(rstn), .init(init), .fetch_ready(fetch_ready),
      .fetch_req(fetch_req4), .fetch_ack(fetch_ack), .fetch_pc(fetch_pc4), .fetch_cid(fetch_cid4),
      .dec_valid(dec_valid), .dec_cid(dec_cid4), .dec_next_ready(dec_next_ready),
      .dec_next_pc(dec_next_pc), .dec_branch(dec_branch4), .dec_pc_f(dec_pc_f),
      .dec_stall(dec_stall4), .alloc_t_cid(alloc_t4), .alloc_f_cid(alloc_f4),
      .jb_valid(jb_valid), .jb_cid(jb_cid4), .jb_pc(jb_pc),
      .br_valid(br_valid), .br_hazard(br_hazard), .br_bad_cid(bad4), .br_good_cid(good4),
      .squash_mask(squash4), .release_mask(release4), .free_cnt(free4), .stall_cnt(stall_cnt4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      fetch_ack = 0; dec_valid = 0; dec_next_ready = 0; dec_branch = 0;
      dec_cid = 0; dec_next_pc = 0; dec_pc_f = 0;
      jb_valid = 0; jb_cid = 0; jb_pc = 0;
      br_valid = 0; br_hazard = 0; br_bad_cid = 0; br_good_cid = 0;
      release_mask = 0; init = 0;
   endtask

   initial begin
      rstn = 0; fetch_ready = 0; phase2 = 0;
      clear_inputs();
      tick(); tick();

      check("rst_fetch_req", 64'(fetch_req8), 64'd0);
      check("rst_squash", 64'(squash8), 64'd0);
      check("rst_free_cnt", 64'(free8), 64'd7);
      check("rst_dec_stall", 64'(dec_stall8), 64'd0);
      check("rst_stall_cnt", 64'(stall_cnt8), 64'd0);
      check("rst_alloc_t", 64'(alloc_t8), 64'd1);
      check("rst_alloc_f", 64'(alloc_f8), 64'd2);
      check("rst_free_cnt4", 64'(free4), 64'd3);

      rstn = 1; fetch_ready = 1; #1;
      check("boot_fetch_req", 64'(fetch_req8), 64'd1);
      check("boot_fetch_pc", 64'(fetch_pc8), 64'h100);
      check("boot_fetch_cid", 64'(fetch_cid8), 64'd0);
      fetch_ack = 1; tick(); clear_inputs(); #1;
      check("ack_fetch_req", 64'(fetch_req8), 64'd0);

      // branch in context 0: taken 0x200, fall-through 0x104
      dec_valid = 1; dec_cid = 0; dec_branch = 1; dec_next_pc = 32'h200; dec_pc_f = 32'h104;
      tick(); clear_inputs(); #1;
      check("br1_fetch_req", 64'(fetch_req8), 64'd1);
      check("br1_fetch_pc", 64'(fetch_pc8), 64'h200);
      check("br1_fetch_cid", 64'(fetch_cid8), 64'd1);
      check("br1_free_cnt", 64'(free8), 64'd5);
      check("br1_alloc_t", 64'(alloc_t8), 64'd3);
      check("br1_alloc_f", 64'(alloc_f8), 64'd4);
      br_valid = 1; br_hazard = 1; br_bad_cid = 0; #1;
      check("br1_kill0", 64'(squash8), 64'h07);
      br_valid = 0; br_hazard = 0; #1;
      check("br1_no_squash", 64'(squash8), 64'h00);

      fetch_ack = 1; tick(); clear_inputs();
      // nested branch in context 1: taken 0x400, fall-through 0x204
      dec_valid = 1; dec_cid = 1; dec_branch = 1; dec_next_pc = 32'h400; dec_pc_f = 32'h204;
      tick(); clear_inputs(); #1;
      check("br2_fetch_cid", 64'(fetch_cid8), 64'd3);
      check("br2_fetch_pc", 64'(fetch_pc8), 64'h400);
      check("br2_free_cnt", 64'(free8), 64'd3);
      br_valid = 1; br_hazard = 1; br_bad_cid = 0; #1;
      check("br2_kill0", 64'(squash8), 64'h1F);
      br_valid = 0; br_hazard = 0; #1;

      // mispredict 1 (good 2) with jump on 2 and a decode from dying context 1
      br_valid = 1; br_hazard = 1; br_bad_cid = 1; br_good_cid = 2;
      jb_valid = 1; jb_cid = 2; jb_pc = 32'h300;
      dec_valid = 1; dec_cid = 1; dec_next_ready = 1; dec_branch = 1;
      dec_next_pc = 32'h500; dec_pc_f = 32'h508;
      #1;
      check("mis_squash", 64'(squash8), 64'h1A);
      check("mis_fetch_cid", 64'(fetch_cid8), 64'd2);
      check("mis_fetch_req", 64'(fetch_req8), 64'd1);
      tick(); clear_inputs(); #1;
      check("mis_free_cnt", 64'(free8), 64'd6);
      check("mis_fetch_pc", 64'(fetch_pc8), 64'h300);
      check("mis_fetch_cid2", 64'(fetch_cid8), 64'd2);
      check("mis_alloc_t", 64'(alloc_t8), 64'd1);
      check("mis_alloc_f", 64'(alloc_f8), 64'd3);
      br_valid = 1; br_hazard = 1; br_bad_cid = 0; #1;
      check("mis_kill0", 64'(squash8), 64'h05);
      br_valid = 0; br_hazard = 0; #1;

      fetch_ack = 1; tick(); clear_inputs(); #1;
      check("ack2_fetch_req", 64'(fetch_req8), 64'd0);

      // decode next-pc beats a jump on the same context
      jb_valid = 1; jb_cid = 2; jb_pc = 32'h700;
      dec_valid = 1; dec_cid = 2; dec_next_ready = 1; dec_next_pc = 32'h600;
      tick(); clear_inputs(); #1;
      check("prio_fetch_req", 64'(fetch_req8), 64'd1);
      check("prio_fetch_pc", 64'(fetch_pc8), 64'h600);

      // release 0 and hot 2: only 0 is freed
      release_mask = 8'h05;
      tick(); clear_inputs(); #1;
      check("rel_free_cnt", 64'(free8), 64'd7);
      check("rel_alloc_t", 64'(alloc_t8), 64'd0);
      check("rel_alloc_f", 64'(alloc_f8), 64'd1);
      check("rel_fetch_cid", 64'(fetch_cid8), 64'd2);

      init = 1;
      tick(); clear_inputs(); #1;
      check("init_fetch_pc", 64'(fetch_pc8), 64'h100);
      check("init_fetch_cid", 64'(fetch_cid8), 64'd0);
      check("init_fetch_req", 64'(fetch_req8), 64'd1);
      check("init_free_cnt", 64'(free8), 64'd7);

      // four-context instance: back-pressure after one branch
      rstn = 0; tick(); rstn = 1; phase2 = 1; #1;
      check("n4_rst_free", 64'(free4), 64'd3);
      check("n4_rst_stall", 64'(dec_stall4), 64'd0);
      dec_valid = 1; dec_cid = 0; dec_branch = 1; dec_next_pc = 32'h200; dec_pc_f = 32'h104;
      tick(); clear_inputs(); #1;
      check("n4_br_stall", 64'(dec_stall4), 64'd1);
      check("n4_br_free", 64'(free4), 64'd1);
      check("n4_br_fetch_pc", 64'(fetch_pc4), 64'h200);
      check("n4_br_alloc_t", 64'(alloc_t4), 64'd3);

      dec_valid = 1; dec_cid = 0;
      repeat (5) tick();
      clear_inputs(); #1;
`ifdef CNTX_STALL_CNT_EN
      check("n4_stall_cnt", 64'(stall_cnt4), 64'd5);
`else
      check("n4_stall_cnt", 64'(stall_cnt4), 64'd0);
`endif
      check("n8_stall_cnt", 64'(stall_cnt8), 64'd0);

      release_mask = 8'h01;
      tick(); clear_inputs(); #1;
      check("n4_rel_free", 64'(free4), 64'd2);
      check("n4_rel_stall", 64'(dec_stall4), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
